sparc_ifu_fpcgen: RTL and testbench
===================================

# sparc_ifu_fpcgen

Per-thread fetch-PC generator for the IFU: holds the 46-bit fetch PC of each of four threads, hands out the current PC when the fetch control grants a thread, and advances that thread's PC through one combinational instance of the 46-bit PC incrementer. It consumes the incrementer's sum and overflow flag. An overflow from bit 45 = 0 into bit 45 = 1 is reported as a VA-hole crossing and parks the thread until a redirect arrives. Branch and trap redirects load a new PC directly.

## Interface
- RST_PC, 46'h0, PC loaded into every thread on reset.
- rclk  in  1  core clock; all state on the rising edge.
- arst_l  in  1  reset, asynchronous, active-low.
- thr_en  in  4  thread enable; a disabled thread rejects fetches but accepts redirects.
- fetch_vld  in  1  fetch grant this cycle.
- fetch_tid  in  2  granted thread.
- rdr_vld  in  1  redirect (branch/trap) this cycle.
- rdr_tid  in  2  redirected thread.
- rdr_pc  in  46  new PC.
- fpc_vld  out  1  registered: fetch accepted last cycle.
- fpc  out  46  registered: PC that was fetched.
- fpc_tid  out  2  registered: thread of fpc.
- fetch_rej  out  1  registered: fetch rejected last cycle (tid in fpc_tid).
- hole_vld  out  1  registered one-cycle pulse: the advanced PC entered the VA hole.
- hole_tid  out  2  registered: thread for hole_vld.
- thr_hole  out  4  per-thread parked-in-hole state.

## Operation
- Per-thread state is pc[t] (46 b) and st[t] ∈ {RUN, HOLE}. Reset sets pc = RST_PC and st = RUN.
- A fetch is accepted when fetch_vld & thr_en[fetch_tid] & st[fetch_tid]==RUN & ~(rdr_vld & rdr_tid==fetch_tid).
- On an accepted fetch:
  - fpc ← pc[tid], fpc_tid ← tid, fpc_vld ← 1.
  - pc[tid] ← pc[tid]+1, using the incrementer sum.
  - If the incrementer overflow flag is set: st[tid] ← HOLE, hole_vld ← 1, hole_tid ← tid.
- A fetch with fetch_vld=1 that is not accepted: fetch_rej ← 1, fpc_tid ← fetch_tid, fpc_vld ← 0, and no PC change.
- On redirect: pc[rdr_tid] ← rdr_pc and st[rdr_tid] ← RUN. This applies whatever the thread's state or thr_en.
- Redirect and fetch to the same thread in one cycle: the redirect wins and the fetch is rejected.
- Redirect and fetch to different threads: both take effect.
- Wrap-around: 46'h3fff_ffff_ffff + 1 = 0 with overflow 0. The thread stays RUN and no hole is reported.
- The fetched PC itself is always legal; only the next PC lies in the hole.
- At most one increment per cycle, so a single incrementer instance suffices. Its input is muxed from pc[fetch_tid].

## Timing
- One-cycle latency: request in cycle N → fpc / fpc_vld / fetch_rej / hole_vld valid in N+1. Each is a single-cycle pulse unless the request repeats.
- pc[] and st[] update at the end of cycle N. A fetch of the same thread in N+1 sees the advanced PC (back-to-back fetch allowed).
- A redirect in N is visible to a fetch in N+1.
- Reset values:
  - fpc_vld = 0, fetch_rej = 0, hole_vld = 0.
  - fpc = 0, fpc_tid = 0, hole_tid = 0, thr_hole = 4'b0.
  - pc[t] = RST_PC.
- Reset asserted mid-operation clears everything asynchronously. A request coinciding with reset release is ignored if arst_l is low at the edge.
- Combinational path: pc mux → incrementer → pc register. There is no path from inputs to outputs.

## Structure
- Shared IFU package/defines: thread-count constant (4), TID width (2), PC width (46), st encoding (RUN=0, HOLE=1).
- One sub-module instance: the existing 46-bit incrementer sparc_ifu_incr46, fed from the pc[fetch_tid] mux.
- Remaining logic (four PC registers, state bits, output flops) stays flat in this module.

## Test plan
- Reset with RST_PC=46'h100, then fetch t2 three back-to-back cycles → fpc = 46'h100, 46'h101, 46'h102 with fpc_tid=2. pc[0,1,3] remain 46'h100.
- Redirect t1 to 46'h1fff_ffff_ffff, then fetch t1 twice:
  - first fetch → fpc=46'h1fff_ffff_ffff, hole_vld=1, hole_tid=1, thr_hole=4'b0010;
  - second fetch → fetch_rej=1, fpc_vld=0.
  - Redirect t1 to 46'h40 → thr_hole=0; next fetch gives fpc=46'h40.
- Redirect t0 to 46'h3fff_ffff_ffff, fetch t0 → fpc=46'h3fff_ffff_ffff, no hole_vld; next fetch gives fpc=0.
- Same cycle: fetch t3 + redirect t3 to 46'h80 → fetch_rej=1; next fetch gives fpc=46'h80. Repeat with fetch t0 + redirect t3 → t0 fetch accepted, t3 loaded.
- thr_en=4'b1011, fetch t2 → fetch_rej=1 and pc[2] unchanged. Redirect t2 to 46'h200 is still loaded and is visible once thr_en[2]=1.
- Assert arst_l low during a back-to-back fetch stream → all outputs go to their reset values immediately. After release, the first fetch of each thread returns RST_PC.

Source files
------------

// File: rtl/sparc_ifu_fpcgen_pkg.sv
// Shared IFU definitions for the fetch-PC generator.
//   NumThr : number of hardware threads
//   TidW   : thread-id width
//   PcW    : fetch-PC width
//   st_e   : per-thread fetch state (RUN / parked in VA hole)
package sparc_ifu_fpcgen_pkg;

  localparam int unsigned NumThr = 4;
  localparam int unsigned TidW   = 2;
  localparam int unsigned PcW    = 46;

  typedef enum logic {
    StRun  = 1'b0,
    StHole = 1'b1
  } st_e;

endpackage

// File: rtl/sparc_ifu_incr46.sv
// 46-bit PC incrementer.
//   a   : PC to advance
//   sum : a + 1 (wraps modulo 2^46)
//   ofl : set when bit 45 goes 0 -> 1, i.e. the next PC enters the VA hole
module sparc_ifu_incr46
  import sparc_ifu_fpcgen_pkg::*;
(
  input  logic [PcW-1:0] a,
  output logic [PcW-1:0] sum,
  output logic           ofl
);

  assign sum = a + PcW'(1);
  // Full wrap (all ones -> 0) clears bit 45, so it never flags overflow.
  assign ofl = ~a[PcW-1] & sum[PcW-1];

endmodule

// File: rtl/sparc_ifu_fpcgen.sv
// Per-thread fetch-PC generator.
//   rclk, arst_l        : clock, async active-low reset
//   thr_en              : per-thread fetch enable (redirects ignore it)
//   fetch_vld/fetch_tid : fetch grant and thread
//   rdr_vld/rdr_tid/rdr_pc : branch/trap redirect
//   fpc_vld/fpc/fpc_tid : registered fetched PC and its thread
//   fetch_rej           : registered fetch reject (thread in fpc_tid)
//   hole_vld/hole_tid   : registered pulse, advanced PC entered the VA hole
//   thr_hole            : per-thread parked-in-hole state
module sparc_ifu_fpcgen
  import sparc_ifu_fpcgen_pkg::*;
#(
  parameter logic [PcW-1:0] RST_PC = '0
) (
  input  logic              rclk,
  input  logic              arst_l,
  input  logic [NumThr-1:0] thr_en,
  input  logic              fetch_vld,
  input  logic [TidW-1:0]   fetch_tid,
  input  logic              rdr_vld,
  input  logic [TidW-1:0]   rdr_tid,
  input  logic [PcW-1:0]    rdr_pc,
  output logic              fpc_vld,
  output logic [PcW-1:0]    fpc,
  output logic [TidW-1:0]   fpc_tid,
  output logic              fetch_rej,
  output logic              hole_vld,
  output logic [TidW-1:0]   hole_tid,
  output logic [NumThr-1:0] thr_hole
);

  logic [PcW-1:0] pc_q [NumThr];
  logic [PcW-1:0] pc_d [NumThr];
  st_e            st_q [NumThr];
  st_e            st_d [NumThr];

  logic           rdr_hit;
  logic           fetch_ok;
  logic [PcW-1:0] incr_in;
  logic [PcW-1:0] incr_sum;
  logic           incr_ofl;

  // A redirect to the granted thread takes priority over its fetch.
  assign rdr_hit  = rdr_vld & (rdr_tid == fetch_tid);
  assign fetch_ok = fetch_vld & thr_en[fetch_tid] & (st_q[fetch_tid] == StRun) & ~rdr_hit;

  // Single shared incrementer, fed from the granted thread's PC.
  assign incr_in = pc_q[fetch_tid];

  sparc_ifu_incr46 u_incr (
    .a   (incr_in),
    .sum (incr_sum),
    .ofl (incr_ofl)
  );

  // State register: per-thread PC and fetch state.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      for (int t = 0; t < NumThr; t++) begin
        pc_q[t] <= RST_PC;
        st_q[t] <= StRun;
      end
    end else begin
      for (int t = 0; t < NumThr; t++) begin
        pc_q[t] <= pc_d[t];
        st_q[t] <= st_d[t];
      end
    end
  end

  // Next state: fetch advance, then redirect (different threads never collide here).
  always_comb begin
    for (int t = 0; t < NumThr; t++) begin
      pc_d[t] = pc_q[t];
      st_d[t] = st_q[t];
      if (fetch_ok && (fetch_tid == TidW'(t))) begin
        pc_d[t] = incr_sum;
        if (incr_ofl) begin
          st_d[t] = StHole;
        end
      end
      if (rdr_vld && (rdr_tid == TidW'(t))) begin
        pc_d[t] = rdr_pc;
        st_d[t] = StRun;
      end
    end
  end

  // Outputs derived from state.
  always_comb begin
    thr_hole = '0;
    for (int t = 0; t < NumThr; t++) begin
      thr_hole[t] = (st_q[t] == StHole);
    end
  end

  // Registered fetch response; data fields hold between pulses.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      fpc_vld   <= 1'b0;
      fpc       <= '0;
      fpc_tid   <= '0;
      fetch_rej <= 1'b0;
      hole_vld  <= 1'b0;
      hole_tid  <= '0;
    end else begin
      fpc_vld   <= fetch_ok;
      fetch_rej <= fetch_vld & ~fetch_ok;
      hole_vld  <= fetch_ok & incr_ofl;
      if (fetch_vld) begin
        fpc_tid <= fetch_tid;
      end
      if (fetch_ok) begin
        fpc <= pc_q[fetch_tid];
      end
      if (fetch_ok && incr_ofl) begin
        hole_tid <= fetch_tid;
      end
    end
  end

endmodule

// File: tb/tb_sparc_ifu_fpcgen.sv
module tb_sparc_ifu_fpcgen;

  localparam logic [45:0] RstPc    = 46'h100;
  localparam logic [46:0] HoleBase = 47'h2000_0000_0000;

  logic        rclk;
  logic        arst_l;
  logic [3:0]  thr_en;
  logic        fetch_vld;
  logic [1:0]  fetch_tid;
  logic        rdr_vld;
  logic [1:0]  rdr_tid;
  logic [45:0] rdr_pc;
  logic        fpc_vld;
  logic [45:0] fpc;
  logic [1:0]  fpc_tid;
  logic        fetch_rej;
  logic        hole_vld;
  logic [1:0]  hole_tid;
  logic [3:0]  thr_hole;

  sparc_ifu_fpcgen #(.RST_PC(RstPc)) dut (
    .rclk      (rclk),
    .arst_l    (arst_l),
    .thr_en    (thr_en),
    .fetch_vld (fetch_vld),
    .fetch_tid (fetch_tid),
    .rdr_vld   (rdr_vld),
    .rdr_tid   (rdr_tid),
    .rdr_pc    (rdr_pc),
    .fpc_vld   (fpc_vld),
    .fpc       (fpc),
    .fpc_tid   (fpc_tid),
    .fetch_rej (fetch_rej),
    .hole_vld  (hole_vld),
    .hole_tid  (hole_tid),
    .thr_hole  (thr_hole)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  typedef struct {
    bit          acc;
    logic [45:0] pc;
    logic [1:0]  tid;
    bit          hole;
    logic [3:0]  thr;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;

  // Reference model: architectural view of each thread.
  logic [45:0] pc_m   [4];
  bit          hole_m [4];
  logic [3:0]  en_m;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  function automatic void model_reset();
    for (int t = 0; t < 4; t++) begin
      pc_m[t]   = RstPc;
      hole_m[t] = 1'b0;
    end
  endfunction

  // One request cycle: drive, update model, queue the expected response.
  task automatic cyc(input bit fv, input logic [1:0] ft, input bit rv,
                     input logic [1:0] rt, input logic [45:0] rpc);
    exp_t        e;
    logic [46:0] nxt;
    @(posedge rclk);
    #1;
    thr_en    = en_m;
    fetch_vld = fv;
    fetch_tid = ft;
    rdr_vld   = rv;
    rdr_tid   = rt;
    rdr_pc    = rpc;
    e.acc  = fv && en_m[ft] && !hole_m[ft] && !(rv && rt == ft);
    e.tid  = ft;
    e.pc   = pc_m[ft];
    e.hole = 1'b0;
    if (e.acc) begin
      nxt    = {1'b0, pc_m[ft]} + 47'd1;
      e.hole = ({1'b0, pc_m[ft]} < HoleBase) && (nxt >= HoleBase);
      pc_m[ft] = nxt[45:0];
      if (e.hole) hole_m[ft] = 1'b1;
    end
    if (rv) begin
      pc_m[rt]   = rpc;
      hole_m[rt] = 1'b0;
    end
    for (int t = 0; t < 4; t++) e.thr[t] = hole_m[t];
    if (fv) exp_q.push_back(e);
  endtask

  task automatic fetch(input logic [1:0] ft);
    cyc(1'b1, ft, 1'b0, 2'd0, 46'h0);
  endtask

  task automatic redirect(input logic [1:0] rt, input logic [45:0] rpc);
    cyc(1'b0, 2'd0, 1'b1, rt, rpc);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_fpc_vld"},   64'(fpc_vld),   64'd0);
    chk({tag, "_fetch_rej"}, 64'(fetch_rej), 64'd0);
    chk({tag, "_hole_vld"},  64'(hole_vld),  64'd0);
    chk({tag, "_fpc"},       64'(fpc),       64'd0);
    chk({tag, "_fpc_tid"},   64'(fpc_tid),   64'd0);
    chk({tag, "_hole_tid"},  64'(hole_tid),  64'd0);
    chk({tag, "_thr_hole"},  64'(thr_hole),  64'd0);
  endtask

  // Monitor: pops one expectation whenever the DUT presents a response.
  always @(negedge rclk) begin
    exp_t e;
    if (arst_l) begin
      if (fpc_vld || fetch_rej) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_response", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("fpc_vld",   64'(fpc_vld),   64'(e.acc));
          chk("fetch_rej", 64'(fetch_rej), 64'(!e.acc));
          chk("fpc_tid",   64'(fpc_tid),   64'(e.tid));
          if (e.acc) chk("fpc", 64'(fpc), 64'(e.pc));
          chk("hole_vld",  64'(hole_vld),  64'(e.hole));
          if (e.hole) chk("hole_tid", 64'(hole_tid), 64'(e.tid));
          chk("thr_hole",  64'(thr_hole),  64'(e.thr));
        end
      end else if (hole_vld) begin
        chk("hole_vld_without_fetch", 64'd1, 64'd0);
      end
    end
  end

  initial begin
    logic [63:0] r;
    logic [45:0] rpc;
    arst_l    = 1'b0;
    thr_en    = 4'hf;
    fetch_vld = 1'b0;
    fetch_tid = 2'd0;
    rdr_vld   = 1'b0;
    rdr_tid   = 2'd0;
    rdr_pc    = 46'h0;
    en_m      = 4'hf;
    model_reset();
    #1;
    check_reset_outputs("rst");
    @(posedge rclk);
    @(posedge rclk);
    #2 arst_l = 1'b1;

    // Back-to-back fetches of t2; other threads untouched.
    fetch(2'd2); fetch(2'd2); fetch(2'd2);
    fetch(2'd0); fetch(2'd1); fetch(2'd3);

    // VA-hole entry, parking, and release by redirect.
    redirect(2'd1, 46'h1fff_ffff_ffff);
    fetch(2'd1); fetch(2'd1);
    redirect(2'd1, 46'h40);
    fetch(2'd1);

    // Full wrap is not a hole.
    redirect(2'd0, 46'h3fff_ffff_ffff);
    fetch(2'd0); fetch(2'd0);

    // Same-thread redirect beats fetch; different threads both proceed.
    cyc(1'b1, 2'd3, 1'b1, 2'd3, 46'h80);
    fetch(2'd3);
    cyc(1'b1, 2'd0, 1'b1, 2'd3, 46'h90);
    fetch(2'd3);

    // Disabled thread rejects fetch but accepts redirect.
    en_m = 4'b1011;
    fetch(2'd2);
    redirect(2'd2, 46'h200);
    en_m = 4'b1111;
    fetch(2'd2);

    // Async reset in the middle of a fetch stream.
    fetch(2'd2); fetch(2'd2); fetch(2'd2);
    #6;
    arst_l = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    fetch_vld = 1'b0;
    rdr_vld   = 1'b0;
    model_reset();
    @(posedge rclk);
    #2 arst_l = 1'b1;
    fetch(2'd0); fetch(2'd1); fetch(2'd2); fetch(2'd3);

    // Randomized traffic, biased toward the hole and wrap boundaries.
    for (int i = 0; i < 500; i++) begin
      r = {$urandom(), $urandom()};
      case ($urandom_range(0, 3))
        0: rpc = r[45:0];
        1: rpc = 46'h1fff_ffff_fffe + 46'(r[0]);
        2: rpc = 46'h3fff_ffff_fffe + 46'(r[0]);
        default: rpc = 46'(r[7:0]);
      endcase
      en_m = ($urandom_range(0, 9) == 0) ? 4'($urandom()) : 4'hf;
      cyc($urandom_range(0, 9) < 7, 2'($urandom()),
          $urandom_range(0, 3) == 0, 2'($urandom()), rpc);
    end

    en_m = 4'hf;
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'd0, 1'b0, 2'd0, 46'h0);
    @(negedge rclk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
